// File: rtl/dl11_console_ctrl_if.sv
// dl11_console_ctrl_if: CPU-side register bus for the DL11 console.
// master drives strobes/address/data, slave returns registered read data.
interface dl11_console_ctrl_if;
    logic [1:0]  reg_addr;
    logic        reg_rd;
    logic        reg_wr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;

    modport master (
        output reg_addr, reg_rd, reg_wr, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr, reg_rd, reg_wr, reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/dl11_console_ctrl.sv
// dl11_console_ctrl: DL11 RCSR/RBUF/XCSR/XBUF over a uart_tx/uart_rx pair.
// Define DL11_RX_FIFO_EN to put an RX_FIFO_DEPTH-entry FIFO ahead of RBUF.
module dl11_console_ctrl #(
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    dl11_console_ctrl_if.slave bus,
    output logic               rx_irq,
    output logic               tx_irq,
    output logic [7:0]         tx_data,
    output logic               tx_send,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_data_ready,
    output logic               rx_clear
);
    typedef enum logic [1:0] {T_IDLE, T_ARM, T_SEND, T_BUSY} tx_state_t;

    tx_state_t  state, state_nxt;
    logic       sel_rcsr, sel_rbuf, sel_xcsr, sel_xbuf;
    logic       rd_rbuf, wr_xbuf, cap;
    logic       ready, rie, tie, done, ovr;
    logic [7:0] rbuf_q;

    if (RX_FIFO_DEPTH < 2 ||
        (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("RX_FIFO_DEPTH must be a power of 2, at least 2");
    end

    assign sel_rcsr = (bus.reg_addr == 2'd0);
    assign sel_rbuf = (bus.reg_addr == 2'd1);
    assign sel_xcsr = (bus.reg_addr == 2'd2);
    assign sel_xbuf = (bus.reg_addr == 2'd3);

    // READY is registered state only, so a write racing its return is dropped
    assign ready   = (state == T_IDLE);
    assign rd_rbuf = bus.reg_rd & sel_rbuf;
    assign wr_xbuf = bus.reg_wr & sel_xbuf & ready;
    assign cap     = rx_data_ready & ~rx_clear;

    assign rx_irq = rie & done;
    assign tx_irq = tie & ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= T_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_send   = 1'b0;
        unique case (state)
            T_IDLE: if (wr_xbuf) state_nxt = T_ARM;
            T_ARM: begin
                if (tx_ready) begin
                    tx_send   = 1'b1;
                    state_nxt = T_SEND;
                end
            end
            T_SEND: begin
                tx_send = 1'b1;
                if (!tx_ready) state_nxt = T_BUSY;
            end
            T_BUSY: if (tx_ready) state_nxt = T_IDLE;
            default: state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rie      <= 1'b0;
            tie      <= 1'b0;
            tx_data  <= '0;
            rx_clear <= 1'b0;
        end else begin
            rx_clear <= cap;
            if (bus.reg_wr && sel_rcsr) rie <= bus.reg_wdata[6];
            if (bus.reg_wr && sel_xcsr) tie <= bus.reg_wdata[6];
            if (wr_xbuf) tx_data <= bus.reg_wdata[7:0];
        end
    end

`ifdef DL11_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          full, pop, push;

    assign done   = (cnt != '0);
    assign full   = (cnt == (AW + 1)'(RX_FIFO_DEPTH));
    assign pop    = rd_rbuf & done;
    // a push into a full FIFO only lands if the head leaves on the same edge
    assign push   = cap & (~full | pop);
    assign rbuf_q = done ? fifo_mem[rp] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wp] <= rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovr <= 1'b0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            if (push && !pop)      cnt <= cnt + (AW + 1)'(1);
            else if (pop && !push) cnt <= cnt - (AW + 1)'(1);
            if (pop)                     ovr <= 1'b0;
            else if (cap && full)        ovr <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rbuf_q <= '0;
            done   <= 1'b0;
            ovr    <= 1'b0;
        end else if (cap) begin
            rbuf_q <= rx_data;
            done   <= 1'b1;
            ovr    <= (ovr | done) & ~rd_rbuf;
        end else if (rd_rbuf) begin
            done <= 1'b0;
            ovr  <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.reg_rdata <= '0;
        end else if (bus.reg_rd) begin
            unique case (1'b1)
                sel_rcsr: bus.reg_rdata <= {8'h00, done, rie, 6'h00};
                sel_rbuf: bus.reg_rdata <= {ovr, ovr, 6'h00, rbuf_q};
                sel_xcsr: bus.reg_rdata <= {8'h00, ready, tie, 6'h00};
                sel_xbuf: bus.reg_rdata <= '0;
                default:  bus.reg_rdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_dl11_console_ctrl.sv
// tb_dl11_console_ctrl: directed scoreboard bench for dl11_console_ctrl.
// Reads queue expected data; a negedge monitor pops and compares.
module tb_dl11_console_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_ready = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_send, rx_clear, rx_irq, tx_irq;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_send = 0;
    int         n_clear = 0;
    logic       send_q = 1'b0;
    logic       rd_seen = 1'b0;
    logic [15:0] exp_q[$];
    string      name_q[$];

    dl11_console_ctrl_if bus();

    dl11_console_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .rx_irq       (rx_irq),
        .tx_irq       (tx_irq),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .rx_clear     (rx_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) rd_seen <= bus.reg_rd;

    always @(negedge clk) begin
        if (tx_send && !send_q) n_send++;
        send_q = tx_send;
        if (rx_clear) n_clear++;
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rdata_unexpected: got %h required none",
                         bus.reg_rdata);
            end else begin
                chk(name_q.pop_front(), bus.reg_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic rd(input logic [1:0] a, input logic [15:0] e,
                      input string nm);
        bus.reg_addr = a;
        bus.reg_rd   = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
        bus.reg_rd = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_wr    = 1'b1;
        @(posedge clk); #1;
        bus.reg_wr = 1'b0;
    endtask

    // receiver model: hold the byte until rx_clear is seen, then drop
    task automatic rx_byte(input logic [7:0] b);
        bit seen = 1'b0;
        rx_data       = b;
        rx_data_ready = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            seen = rx_clear;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rx_handshake: rx_clear got 0 required 1");
        end
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.reg_addr  = 2'd0;
        bus.reg_rd    = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_wdata = 16'h0000;
        #3;
        chk("rst_rdata", bus.reg_rdata, 16'h0000);
        chk("rst_tx_data", {8'h00, tx_data}, 16'h0000);
        chk("rst_tx_send", {15'd0, tx_send}, 16'h0000);
        chk("rst_rx_clear", {15'd0, rx_clear}, 16'h0000);
        chk("rst_irqs", {14'd0, rx_irq, tx_irq}, 16'h0000);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        rd(2'd0, 16'h0000, "rcsr_rst");
        rd(2'd2, 16'h0080, "xcsr_rst");

        // transmit with a dropped second write
        wr(2'd2, 16'h0040);
        chk("tx_irq_tie", {15'd0, tx_irq}, 16'h0001);
        wr(2'd3, 16'h0141);
        chk("tx_data_41", {8'h00, tx_data}, 16'h0041);
        chk("tx_send_arm", {15'd0, tx_send}, 16'h0001);
        rd(2'd2, 16'h0040, "xcsr_busy");
        wr(2'd3, 16'h0042);
        chk("tx_data_kept", {8'h00, tx_data}, 16'h0041);
        chk("tx_send_hold", {15'd0, tx_send}, 16'h0001);
        tx_ready = 1'b0;
        @(posedge clk); #1;
        chk("tx_send_drop", {15'd0, tx_send}, 16'h0000);
        chk("tx_irq_busy", {15'd0, tx_irq}, 16'h0000);
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("tx_irq_done", {15'd0, tx_irq}, 16'h0001);
        rd(2'd2, 16'h00c0, "xcsr_done");
        chk("tx_episodes", 16'(n_send), 16'd1);

        // receive
        n_clear = 0;
        rx_byte(8'h5a);
        chk("rx_clear_once", 16'(n_clear), 16'd1);
        rd(2'd0, 16'h0080, "rcsr_done");
        chk("rx_irq_off", {15'd0, rx_irq}, 16'h0000);
        wr(2'd0, 16'h0040);
        chk("rx_irq_on", {15'd0, rx_irq}, 16'h0001);
        rd(2'd1, 16'h005a, "rbuf_5a");
        rd(2'd0, 16'h0040, "rcsr_clr");
        chk("rx_irq_clr", {15'd0, rx_irq}, 16'h0000);

        // overrun
        rx_byte(8'h31);
        rx_byte(8'h32);
`ifdef DL11_RX_FIFO_EN
        rd(2'd1, 16'h0031, "fifo_31");
        rd(2'd1, 16'h0032, "fifo_32");
        rd(2'd0, 16'h0040, "fifo_empty");
`else
        rd(2'd1, 16'hc032, "rbuf_ovr");
        rd(2'd0, 16'h0040, "rcsr_ovr_clr");
        rd(2'd1, 16'h0032, "rbuf_err_clr");
`endif

        // RBUF read colliding with a capture
        rx_byte(8'h11);
        rx_data       = 8'h55;
        rx_data_ready = 1'b1;
        rd(2'd1, 16'h0011, "coll_old");
        chk("coll_rx_clear", {15'd0, rx_clear}, 16'h0001);
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
        rd(2'd0, 16'h00c0, "coll_done");
        rd(2'd1, 16'h0055, "coll_new");

        // async reset while in T_SEND
        rx_byte(8'h66);
        chk("pre_rst_rx_irq", {15'd0, rx_irq}, 16'h0001);
        wr(2'd3, 16'h0077);
        @(posedge clk); #1;
        chk("pre_rst_send", {15'd0, tx_send}, 16'h0001);
        chk("pre_rst_data", {8'h00, tx_data}, 16'h0077);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_send", {15'd0, tx_send}, 16'h0000);
        chk("mid_rst_data", {8'h00, tx_data}, 16'h0000);
        chk("mid_rst_rdata", bus.reg_rdata, 16'h0000);
        chk("mid_rst_irqs", {14'd0, rx_irq, tx_irq}, 16'h0000);
        chk("mid_rst_clear", {15'd0, rx_clear}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd(2'd2, 16'h0080, "xcsr_post_rst");
        rd(2'd0, 16'h0000, "rcsr_post_rst");
        rd(2'd1, 16'h0000, "rbuf_post_rst");

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drain", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dl11_console_ctrl.md
# dl11_console_ctrl

DL11-compatible console controller that exposes the serial port as the four PDP-11 console registers: RCSR, RBUF, XCSR and XBUF. It sits between the CPU-side register bus and the `uart_tx`/`uart_rx` pair. It sequences the send/ready handshake of the transmitter and drains the receiver's ready/clear handshake into a CPU-visible buffer. It also generates receive and transmit interrupt requests.

## Interface
- `RX_FIFO_DEPTH`, default 4: RX FIFO entries (power of 2). Used only when `DL11_RX_FIFO_EN` is defined.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `reg_addr` in 2: register select. 0=RCSR, 1=RBUF, 2=XCSR, 3=XBUF (word offsets from 177560).
- `reg_rd` in 1: one-cycle read strobe.
- `reg_wr` in 1: one-cycle write strobe.
- `reg_wdata` in 16: write data.
- `reg_rdata` out 16: registered read data, valid the cycle after `reg_rd`.
- `rx_irq` out 1: receive interrupt request, level.
- `tx_irq` out 1: transmit interrupt request, level.
- `tx_data` out 8: byte to the transmitter.
- `tx_send` out 1: send request to the transmitter.
- `tx_ready` in 1: transmitter idle and ready.
- `rx_data` in 8: received byte.
- `rx_data_ready` in 1: receiver holds a byte.
- `rx_clear` out 1: one-cycle pulse that acknowledges the receiver.

## Operation
- **RCSR:**
  - bit7 DONE: read-only; set on byte capture, cleared by an RBUF read.
  - bit6 RIE: read/write.
  - Other bits read 0.
- **RBUF:**
  - bits7:0 data; bit15 ERR; bit14 OVR.
  - ERR and OVR are cleared by an RBUF read.
  - Writes are ignored.
- **XCSR:**
  - bit7 READY: read-only.
  - bit6 TIE: read/write.
  - Other bits read 0.
- **XBUF:**
  - Write latches `reg_wdata[7:0]` into `tx_data` and clears READY, only when READY=1.
  - A write while READY=0 is dropped.
  - Reads return 0.
- **RX capture (single-buffer build):** when `rx_data_ready`=1 and `rx_clear` was not asserted in the previous cycle:
  - copy `rx_data` to RBUF;
  - set DONE;
  - pulse `rx_clear` for one cycle.
  - If DONE was already set, also set OVR and ERR; the new byte overwrites.
- **TX FSM:**
  - T_IDLE (READY=1): XBUF write → T_ARM.
  - T_ARM: wait until `tx_ready`=1, then drive `tx_send`=1 → T_SEND.
  - T_SEND: hold `tx_send`=1 until `tx_ready`=0 → T_BUSY.
  - T_BUSY: `tx_send`=0; wait until `tx_ready`=1 → T_IDLE, and set READY.
  - `tx_send` is high only in T_SEND and T_ARM's exit cycle.
- **Interrupts:** `rx_irq` = RIE & DONE; `tx_irq` = TIE & READY. Both are combinational from registered flags.

## Timing
- **Reset values:**
  - `reg_rdata`=0, `tx_data`=0, `tx_send`=0, `rx_clear`=0.
  - `rx_irq`=0, `tx_irq`=0.
  - READY=1, DONE=0, RIE=TIE=0, ERR=OVR=0.
  - TX FSM in T_IDLE; FIFO empty.
- **Register read:** `reg_rdata` updates on the edge after `reg_rd` and holds until the next read.
- **Read side effects:** an RBUF read returns pre-clear values; the flags clear on the same edge.
- **RX latency:** DONE and `rx_clear` assert one cycle after `rx_data_ready` is sampled high.
- **TX timing:**
  - READY falls the cycle after the XBUF write.
  - `tx_send` rises at the earliest 1 cycle later.
  - READY returns 1 cycle after `tx_ready` reasserts at the end of the character.
- **Simultaneous RBUF read and capture:**
  - The capture wins: DONE stays 1 and RBUF takes the new byte.
  - The read returns the old byte.
  - OVR is not set, because the old byte was consumed.
- **Simultaneous XBUF write and READY returning 1:** the write is dropped; READY only counts as registered state.
- **Reset mid-character:** everything returns to reset values immediately. The partial byte is abandoned with no error flag.

## Configuration
- **`DL11_RX_FIFO_EN` defined:** an `RX_FIFO_DEPTH`-entry FIFO sits between `uart_rx` and RBUF.
  - A capture pushes the byte and pulses `rx_clear`.
  - DONE = FIFO not empty; RBUF shows the head entry.
  - An RBUF read pops the FIFO; DONE clears only when the FIFO empties.
  - A push when full drops the byte and sets OVR/ERR on the current head.
  - A simultaneous push and pop when full is allowed, with no overrun.
- **`DL11_RX_FIFO_EN` undefined:** single RBUF with the overwrite/overrun behaviour described in Operation.

## Test plan
- **Transmit:** XCSR write 0x0040, then XBUF write 0x0141.
  - `tx_data`=0x41 and READY=0.
  - `tx_send` is held until `tx_ready` falls.
  - After `tx_ready` reasserts, XCSR reads 0x00C0 and `tx_irq`=1.
- **Receive:** `rx_data`=0x5A with a `rx_data_ready` pulse.
  - `rx_clear` pulses exactly once.
  - RCSR reads 0x0080.
  - RBUF reads 0x005A; RCSR then reads 0x0000.
- **Overrun:** two bytes 0x31 then 0x32 with no RBUF read.
  - Single-buffer build: RBUF reads 0xC032.
  - FIFO build: reads return 0x0031, then 0x0032, then DONE=0.
- **Dropped write:** XBUF write 0x42 while READY=0 → `tx_data` stays 0x41 and only one `tx_send` episode occurs.
- **Collision:** RBUF read in the same cycle as capture of 0x55 → read returns the old byte, DONE=1, and the next RBUF read returns 0x0055.
- **Async reset in T_SEND:** `tx_send`=0 immediately, READY=1, and every output matches its reset value.
